gtech_reduce_pipe: RTL and testbench

GTECH_REDUCE_PIPE -- requirements
Module: gtech_reduce_pipe

---
 rtl/gtech_reduce_pipe.sv | 114 +++++++++++
 tb/tb_gtech_reduce_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtech_reduce_pipe.sv
// Pipelined AND/OR/XOR reduction tree with optional final inversion; one register
// stage per tree level, with the op carried alongside each partial vector.
module gtech_reduce_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [2:0]       IN_OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             Z,
  output logic             OP_ERR
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PW     = 1 << LEVELS;

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("gtech_reduce_pipe: WIDTH must be in 2..64");
  end

  // Ops 6/7 run as NAND: base AND whenever op[2]==op[1], inverted when op[0] or reserved.
  function automatic logic op_is_and(input logic [2:0] op);
    return op[2] == op[1];
  endfunction

  function automatic logic op_inv(input logic [2:0] op);
    return (op[2] & op[1]) | op[0];
  endfunction

  function automatic logic combine(input logic a, input logic b, input logic [2:0] op);
    case (op[2:1])
      2'b01:   combine = a | b;
      2'b10:   combine = a ^ b;
      default: combine = a & b;
    endcase
  endfunction

  // Handshake: an input transfer happens when IN_VALID & IN_READY, an output
  // transfer when OUT_VALID & OUT_READY; IN_READY never depends on IN_VALID.
  logic [PW-1:0]     leaf;
  logic [PW-1:1]     tree;
  logic [PW-1:1]     tree_nxt;
  logic [PW-1:1]     node_en;
  logic [LEVELS:1]   vld;
  logic [LEVELS:1]   vld_src;
  logic [LEVELS:1]   adv;
  logic [2:0]        op_r   [1:LEVELS];
  logic [2:0]        op_src [1:LEVELS];

  for (genvar j = 0; j < PW; j++) begin : g_leaf
    if (j < WIDTH) begin : g_data
      assign leaf[j] = IN_DATA[j];
    end else begin : g_pad
      assign leaf[j] = op_is_and(IN_OP);
    end
  end

  // A stage advances when it, or any stage after it, is empty, or the consumer takes Z.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    assign adv[k] = OUT_READY | ~(&vld[LEVELS:k]);
    if (k == 1) begin : g_first
      assign vld_src[k] = IN_VALID;
      assign op_src[k]  = IN_OP;
    end else begin : g_next
      assign vld_src[k] = vld[k-1];
      assign op_src[k]  = op_r[k-1];
    end
  end

  // Heap-ordered tree: node i combines children 2i and 2i+1; leaves sit at PW..2PW-1.
  for (genvar i = 1; i < PW; i++) begin : g_node
    localparam int K = LEVELS - $clog2(i + 1) + 1;
    logic a;
    logic b;
    if (2 * i >= PW) begin : g_from_leaf
      assign a = leaf[2*i-PW];
      assign b = leaf[2*i+1-PW];
    end else begin : g_from_tree
      assign a = tree[2*i];
      assign b = tree[2*i+1];
    end
    assign tree_nxt[i] = combine(a, b, op_src[K]);
    assign node_en[i]  = adv[K];
  end

  always_ff @(posedge CLK) begin
    for (int i = 1; i < PW; i++) begin
      if (node_en[i]) tree[i] <= tree_nxt[i];
    end
    for (int k = 1; k <= LEVELS; k++) begin
      if (adv[k]) op_r[k] <= op_src[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      vld <= '0;
    end else begin
      for (int k = 1; k <= LEVELS; k++) begin
        if (adv[k]) vld[k] <= vld_src[k];
      end
    end
  end

  assign IN_READY  = adv[1];
  assign OUT_VALID = vld[LEVELS];
  assign Z         = vld[LEVELS] & (tree[1] ^ op_inv(op_r[LEVELS]));
  assign OP_ERR    = vld[LEVELS] & op_r[LEVELS][2] & op_r[LEVELS][1];

endmodule

// File: tb/tb_gtech_reduce_pipe.sv
// Scoreboard bench for gtech_reduce_pipe at WIDTH=8 and WIDTH=5 (padded tree).
module tb_gtech_reduce_pipe;

  localparam int LEV = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, z8, op_err8;
  logic [7:0] in_data8;
  logic [2:0] in_op8;
  logic       in_valid5, in_ready5, out_valid5, out_ready5, z5, op_err5;
  logic [4:0] in_data5;
  logic [2:0] in_op5;

  gtech_reduce_pipe #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .IN_DATA(in_data8), .IN_OP(in_op8), .OUT_VALID(out_valid8),
    .OUT_READY(out_ready8), .Z(z8), .OP_ERR(op_err8)
  );

  gtech_reduce_pipe #(.WIDTH(5)) u_dut5 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid5), .IN_READY(in_ready5),
    .IN_DATA(in_data5), .IN_OP(in_op5), .OUT_VALID(out_valid5),
    .OUT_READY(out_ready5), .Z(z5), .OP_ERR(op_err5)
  );

  // scoreboard: {op_err, z} expected per accepted operand, plus acceptance cycle
  logic [1:0] exp8_q[$];
  logic [1:0] exp5_q[$];
  int         stamp8_q[$];
  int         stamp5_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         lat_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush_sb();
    exp8_q.delete();
    exp5_q.delete();
    stamp8_q.delete();
    stamp5_q.delete();
  endtask

  // monitors
  always @(negedge clk) begin : mon8
    logic [1:0] e;
    int         s;
    if (rstn === 1'b1 && out_valid8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_w8: got z=%0b with no result expected (cycle %0d)", z8, cyc);
      end else if (out_ready8 === 1'b1) begin
        e = exp8_q.pop_front();
        s = stamp8_q.pop_front();
        chk("z_w8", z8, e[0]);
        chk("op_err_w8", op_err8, e[1]);
        if (lat_chk) chk("latency_w8", cyc - s, LEV);
      end else begin
        chk("stall_z_w8", z8, exp8_q[0][0]);
        chk("stall_err_w8", op_err8, exp8_q[0][1]);
      end
    end
  end

  always @(negedge clk) begin : mon5
    logic [1:0] e;
    int         s;
    if (rstn === 1'b1 && out_valid5 === 1'b1) begin
      if (exp5_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_w5: got z=%0b with no result expected (cycle %0d)", z5, cyc);
      end else if (out_ready5 === 1'b1) begin
        e = exp5_q.pop_front();
        s = stamp5_q.pop_front();
        chk("z_w5", z5, e[0]);
        chk("op_err_w5", op_err5, e[1]);
        if (lat_chk) chk("latency_w5", cyc - s, LEV);
      end
    end
  end

  // drivers
  task automatic send(input bit u5, input logic [7:0] d, input logic [2:0] op,
                      input logic ez, input logic eerr);
    int n    = 0;
    bit done = 1'b0;
    if (u5) begin
      in_valid5 = 1'b1; in_data5 = d[4:0]; in_op5 = op;
    end else begin
      in_valid8 = 1'b1; in_data8 = d; in_op8 = op;
    end
    while (!done && n < 50) begin
      @(negedge clk);
      if ((u5 ? in_ready5 : in_ready8) === 1'b1) begin
        if (u5) begin
          exp5_q.push_back({eerr, ez});
          stamp5_q.push_back(cyc);
        end else begin
          exp8_q.push_back({eerr, ez});
          stamp8_q.push_back(cyc);
        end
        done = 1'b1;
      end
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data %0h op %0d never accepted", d, op);
    end
    @(posedge clk); #1;
    if (u5) in_valid5 = 1'b0;
    else    in_valid8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp8_q.size() != 0 || exp5_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left_w8", exp8_q.size(), 0);
    chk("drain_left_w5", exp5_q.size(), 0);
  endtask

  initial begin
    rstn = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; in_op8 = '0; out_ready8 = 1'b1;
    in_valid5 = 1'b0; in_data5 = '0; in_op5 = '0; out_ready5 = 1'b1;
    @(posedge clk);
    in_valid8 = 1'b1; in_data8 = 8'hFF; in_op8 = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid8, 1'b0);
    chk("rst_z", z8, 1'b0);
    chk("rst_op_err", op_err8, 1'b0);
    chk("rst_in_ready", in_ready8, 1'b1);
    chk("rst_out_valid_w5", out_valid5, 1'b0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    rstn = 1'b1;
    idle(2);

    // single-shot latency
    lat_chk = 1'b1;
    send(0, 8'hFF, 3'd1, 1'b0, 1'b0);
    idle(1);
    drain();

    // back-to-back, mixed ops in flight
    send(0, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(0, 8'h7F, 3'd0, 1'b0, 1'b0);
    send(0, 8'h00, 3'd3, 1'b1, 1'b0);
    send(0, 8'h01, 3'd4, 1'b1, 1'b0);
    send(0, 8'h03, 3'd5, 1'b1, 1'b0);
    send(0, 8'h80, 3'd2, 1'b1, 1'b0);
    send(0, 8'h00, 3'd2, 1'b0, 1'b0);
    send(0, 8'hFE, 3'd1, 1'b1, 1'b0);
    send(0, 8'h5A, 3'd5, 1'b1, 1'b0);
    send(0, 8'h07, 3'd4, 1'b1, 1'b0);
    drain();

    // padded tree, WIDTH=5
    send(1, 8'h1F, 3'd0, 1'b1, 1'b0);
    send(1, 8'h10, 3'd4, 1'b1, 1'b0);
    send(1, 8'h0F, 3'd0, 1'b0, 1'b0);
    send(1, 8'h00, 3'd1, 1'b1, 1'b0);
    send(1, 8'h03, 3'd5, 1'b1, 1'b0);
    send(1, 8'h10, 3'd3, 1'b0, 1'b0);
    drain();

    // reserved ops
    send(0, 8'hFF, 3'd7, 1'b0, 1'b1);
    send(0, 8'hFF, 3'd1, 1'b0, 1'b0);
    send(0, 8'h7F, 3'd6, 1'b1, 1'b1);
    drain();

    // backpressure: three fill the pipe, the fourth waits
    lat_chk = 1'b0;
    out_ready8 = 1'b0;
    send(0, 8'hA5, 3'd2, 1'b1, 1'b0);
    send(0, 8'h00, 3'd0, 1'b0, 1'b0);
    send(0, 8'h0F, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_full", in_ready8, 1'b0);
    chk("bp_out_valid", out_valid8, 1'b1);
    fork
      send(0, 8'h3C, 3'd5, 1'b1, 1'b0);
      begin
        idle(4);
        out_ready8 = 1'b1;
      end
    join
    drain();

    // reset with two operands in flight
    lat_chk = 1'b1;
    send(0, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(0, 8'hFF, 3'd1, 1'b0, 1'b0);
    rstn = 1'b0;
    flush_sb();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid8, 1'b0);
    chk("midrst_in_ready", in_ready8, 1'b1);
    idle(6);

    // recovery after reset
    send(0, 8'h00, 3'd3, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
